// File: rtl/id_decode_pipe.sv
// RV32 decode stage: regfile, control/immediate decode, load-use hazard unit and ID/EX register.
// Optional `ID_WB_BYPASS_EN forwards a same-cycle write-back into the latched read data.
module id_decode_pipe #(
   parameter int XLEN    = 32,
   parameter int NUM_REG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   input  logic            flush,
   input  logic            ex_ready,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1_addr,
   output logic [4:0]      ex_rs2_addr,
   output logic [4:0]      ex_rd_addr,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_funct7,
   output logic [2:0]      ex_alu_op,
   output logic [5:0]      ex_ctrl,
   output logic            ex_illegal
);
   localparam int AW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
   localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
   localparam logic [2:0] ALU_NONE = 3'd7;

   function automatic logic in_range(input logic [4:0] a);
      return (32'(a) < NUM_REG);
   endfunction

   logic [XLEN-1:0] rf_q [NUM_REG];
   logic [XLEN-1:0] rf_d [NUM_REG];

   logic            ex_valid_q, ex_valid_d;
   logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_rs1_data_q, ex_rs1_data_d, ex_rs2_data_q, ex_rs2_data_d;
   logic [XLEN-1:0] ex_imm_q, ex_imm_d;
   logic [4:0]      ex_rs1_addr_q, ex_rs1_addr_d, ex_rs2_addr_q, ex_rs2_addr_d, ex_rd_addr_q, ex_rd_addr_d;
   logic [2:0]      ex_funct3_q, ex_funct3_d, ex_alu_op_q, ex_alu_op_d;
   logic [6:0]      ex_funct7_q, ex_funct7_d;
   logic [5:0]      ex_ctrl_q, ex_ctrl_d;
   logic            ex_illegal_q, ex_illegal_d;

   logic [6:0]        opcode;
   logic [4:0]        rs1, rs2, rd;
   logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
   logic [2:0]        dec_alu;
   logic [5:0]        dec_ctrl;
   logic              legal_op, rs1_used, rs2_used, dec_illegal;
   logic [XLEN-1:0]   rs1_val, rs2_val;
   logic              wb_stall, load_use, advance, issue;

   assign opcode = if_instr[6:0];
   assign rd     = if_instr[11:7];
   assign rs1    = if_instr[19:15];
   assign rs2    = if_instr[24:20];
   assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign imm_u  = {if_instr[31:12], 12'b0};
   assign imm_j  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

   always_comb begin
      dec_alu  = ALU_NONE;
      dec_ctrl = 6'b0;
      imm32    = '0;
      legal_op = 1'b1;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opcode)
         OPC_LUI:    begin dec_alu = 3'd4; dec_ctrl = 6'b100100; imm32 = imm_u; rs1_used = 1'b0; end
         OPC_AUIPC:  begin dec_alu = 3'd5; dec_ctrl = 6'b100100; imm32 = imm_u; rs1_used = 1'b0; end
         OPC_JAL:    begin dec_alu = 3'd6; dec_ctrl = 6'b100001; imm32 = imm_j; rs1_used = 1'b0; end
         OPC_JALR:   begin dec_alu = 3'd6; dec_ctrl = 6'b100101; imm32 = imm_i; end
         OPC_BRANCH: begin dec_alu = 3'd1; dec_ctrl = 6'b000010; imm32 = imm_b; rs2_used = 1'b1; end
         OPC_LOAD:   begin dec_alu = 3'd0; dec_ctrl = 6'b110100; imm32 = imm_i; end
         OPC_STORE:  begin dec_alu = 3'd0; dec_ctrl = 6'b001100; imm32 = imm_s; rs2_used = 1'b1; end
         OPC_OPIMM:  begin dec_alu = 3'd3; dec_ctrl = 6'b100100; imm32 = imm_i; end
         OPC_OP:     begin dec_alu = 3'd2; dec_ctrl = 6'b100000; rs2_used = 1'b1; end
         default:    legal_op = 1'b0;
      endcase
      // rd counts as used only when the instruction writes it back
      dec_illegal = !legal_op || (rs1_used && !in_range(rs1)) || (rs2_used && !in_range(rs2))
                    || (dec_ctrl[5] && !in_range(rd));
   end

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0 && in_range(rs1)) rs1_val = rf_q[rs1[AW-1:0]];
      if (rs2 != 5'd0 && in_range(rs2)) rs2_val = rf_q[rs2[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
      wb_stall = 1'b0;
      if (wb_we && wb_rd != 5'd0 && in_range(wb_rd)) begin
         if (wb_rd == rs1) rs1_val = wb_data;
         if (wb_rd == rs2) rs2_val = wb_data;
      end
`else
      wb_stall = if_valid && wb_we && wb_rd != 5'd0
                 && ((rs1_used && rs1 == wb_rd) || (rs2_used && rs2 == wb_rd));
`endif
   end

   always_comb begin
      rf_d = rf_q;
      if (wb_we && wb_rd != 5'd0 && in_range(wb_rd)) rf_d[wb_rd[AW-1:0]] = wb_data;
   end

   assign advance  = !ex_valid_q || ex_ready;
   assign load_use = ex_valid_q && ex_ctrl_q[4] && ex_rd_addr_q != 5'd0 && if_valid
                     && ((rs1_used && rs1 == ex_rd_addr_q) || (rs2_used && rs2 == ex_rd_addr_q));
   assign id_ready = rst && advance && (!(load_use || wb_stall) || flush);
   assign issue    = if_valid && !flush && !load_use && !wb_stall;

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_pc_d       = ex_pc_q;
      ex_rs1_data_d = ex_rs1_data_q;
      ex_rs2_data_d = ex_rs2_data_q;
      ex_imm_d      = ex_imm_q;
      ex_rs1_addr_d = ex_rs1_addr_q;
      ex_rs2_addr_d = ex_rs2_addr_q;
      ex_rd_addr_d  = ex_rd_addr_q;
      ex_funct3_d   = ex_funct3_q;
      ex_funct7_d   = ex_funct7_q;
      ex_alu_op_d   = ex_alu_op_q;
      ex_ctrl_d     = ex_ctrl_q;
      ex_illegal_d  = ex_illegal_q;
      // bubbles and flushed slots carry no control so EX treats them as inert
      if (advance) begin
         ex_valid_d    = issue;
         ex_pc_d       = if_pc;
         ex_rs1_data_d = rs1_val;
         ex_rs2_data_d = rs2_val;
         ex_imm_d      = XLEN'(imm32);
         ex_rs1_addr_d = rs1;
         ex_rs2_addr_d = rs2;
         ex_rd_addr_d  = rd;
         ex_funct3_d   = if_instr[14:12];
         ex_funct7_d   = if_instr[31:25];
         ex_alu_op_d   = issue ? dec_alu : ALU_NONE;
         ex_ctrl_d     = issue ? dec_ctrl : 6'b0;
         ex_illegal_d  = issue ? dec_illegal : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_q          <= '{default: '0};
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_rs1_addr_q <= '0;
         ex_rs2_addr_q <= '0;
         ex_rd_addr_q  <= '0;
         ex_funct3_q   <= '0;
         ex_funct7_q   <= '0;
         ex_alu_op_q   <= ALU_NONE;
         ex_ctrl_q     <= '0;
         ex_illegal_q  <= 1'b0;
      end else begin
         rf_q          <= rf_d;
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_rs1_addr_q <= ex_rs1_addr_d;
         ex_rs2_addr_q <= ex_rs2_addr_d;
         ex_rd_addr_q  <= ex_rd_addr_d;
         ex_funct3_q   <= ex_funct3_d;
         ex_funct7_q   <= ex_funct7_d;
         ex_alu_op_q   <= ex_alu_op_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_illegal_q  <= ex_illegal_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_rs1_data = ex_rs1_data_q;
   assign ex_rs2_data = ex_rs2_data_q;
   assign ex_imm      = ex_imm_q;
   assign ex_rs1_addr = ex_rs1_addr_q;
   assign ex_rs2_addr = ex_rs2_addr_q;
   assign ex_rd_addr  = ex_rd_addr_q;
   assign ex_funct3   = ex_funct3_q;
   assign ex_funct7   = ex_funct7_q;
   assign ex_alu_op   = ex_alu_op_q;
   assign ex_ctrl     = ex_ctrl_q;
   assign ex_illegal  = ex_illegal_q;
endmodule
